// File: rtl/noc_vc_pkg.sv
// rtl/noc_vc_pkg.sv - shared defaults, derived widths and the plane-sequence helper for the VC drain buffer
package noc_vc_pkg;

    localparam int NOC_VC         = 4;
    localparam int NOC_DATA_WIDTH = 32;
    localparam int NOC_DEPTH      = 4;

    localparam int VC_IDX_W = $clog2(NOC_VC);
    localparam int SEL_W    = NOC_VC + 1;
    localparam int CNT_W    = $clog2(NOC_DEPTH) + 1;

    typedef logic [NOC_DATA_WIDTH-1:0] flit_t;

    // The plane controller advances round-robin; this is the only legal successor.
    function automatic int next_plane(input int prev, input int vc);
        return (prev + 1) % vc;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - single synchronous FIFO with occupancy count and asynchronous reset
module vc_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int C_W   = PTR_W + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [C_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  do_push, do_pop;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign full     = (count_q == C_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vc_plane_drain_buffer.sv
// rtl/vc_plane_drain_buffer.sv - per-VC FIFOs drained by the selected plane; VC_PLANE_CHECK_EN adds the selector checker
module vc_plane_drain_buffer
    import noc_vc_pkg::*;
#(
    parameter int VC         = NOC_VC,
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int DEPTH      = NOC_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [VC:0]                         vc_plane_sel,
    input  logic                                in_valid,
    input  logic [$clog2(VC)-1:0]               in_vc,
    input  logic [DATA_WIDTH-1:0]               in_data,
    output logic                                in_ready,
    output logic                                out_valid,
    output logic [$clog2(VC)-1:0]               out_vc,
    output logic [DATA_WIDTH-1:0]               out_data,
    input  logic                                out_ready,
    output logic [VC*($clog2(DEPTH)+1)-1:0]     vc_count,
    output logic                                sel_error
);

    localparam int IDX_W = $clog2(VC);
    localparam int C_W   = $clog2(DEPTH) + 1;

    logic [VC-1:0]         push, pop, full, empty;
    logic [DATA_WIDTH-1:0] head [VC];
    logic                  sel_in_range;
    logic [IDX_W-1:0]      sel_idx;

    assign sel_in_range = (vc_plane_sel < (VC+1)'(VC));
    assign sel_idx      = vc_plane_sel[IDX_W-1:0];
    assign out_vc       = sel_idx;
    assign in_ready     = !rst && !full[in_vc];
    assign out_valid    = sel_in_range && !empty[sel_idx];
    assign out_data     = out_valid ? head[sel_idx] : '0;

    for (genvar g = 0; g < VC; g++) begin : g_vc
        assign push[g] = in_valid && in_ready && (in_vc == IDX_W'(g));
        assign pop[g]  = out_valid && out_ready && (sel_idx == IDX_W'(g));

        vc_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .push_data (in_data),
            .pop       (pop[g]),
            .pop_data  (head[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .count     (vc_count[g*C_W +: C_W])
        );
    end

`ifdef VC_PLANE_CHECK_EN
    logic [VC:0] prev_sel_q, prev_sel_d;
    logic        prev_vld_q, prev_vld_d;
    logic        sel_error_q, sel_error_d;
    logic        sel_bad;
    logic [VC:0] next_sel;

    // Error is visible in the same cycle the bad selector appears, then held.
    always_comb begin
        next_sel    = (VC+1)'(next_plane(int'(prev_sel_q), VC));
        sel_bad     = 1'b0;
        if (prev_vld_q) begin
            sel_bad = !sel_in_range ||
                      ((vc_plane_sel != prev_sel_q) && (vc_plane_sel != next_sel));
        end
        sel_error_d = sel_error_q || sel_bad;
        prev_sel_d  = vc_plane_sel;
        prev_vld_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sel_q  <= '0;
            prev_vld_q  <= 1'b0;
            sel_error_q <= 1'b0;
        end else begin
            prev_sel_q  <= prev_sel_d;
            prev_vld_q  <= prev_vld_d;
            sel_error_q <= sel_error_d;
        end
    end

    assign sel_error = sel_error_q || sel_bad;
`else
    assign sel_error = 1'b0;
`endif

endmodule

// File: tb/tb_vc_plane_drain_buffer.sv
// tb/tb_vc_plane_drain_buffer.sv - scoreboard bench for vc_plane_drain_buffer
module tb_vc_plane_drain_buffer;

    localparam int VC    = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  vc_plane_sel;
    logic        in_valid;
    logic [1:0]  in_vc;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [1:0]  out_vc;
    logic [31:0] out_data;
    logic        out_ready;
    logic [11:0] vc_count;
    logic        sel_error;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb [VC][$];

    vc_plane_drain_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .vc_plane_sel (vc_plane_sel),
        .in_valid     (in_valid),
        .in_vc        (in_vc),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_vc       (out_vc),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .vc_count     (vc_count),
        .sel_error    (sel_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] vc, input logic [31:0] d,
                         input logic [4:0] sel, input logic ordy);
        logic [11:0] exp_cnt;
        logic        exp_ov;
        logic        acc;
        @(negedge clk);
        in_valid = v; in_vc = vc; in_data = d; vc_plane_sel = sel; out_ready = ordy;
        #1;
        for (int i = 0; i < VC; i++) exp_cnt[i*3 +: 3] = 3'(sb[i].size());
        acc    = v && (sb[vc].size() != DEPTH);
        exp_ov = (sel < 5'd4) && (sb[sel[1:0]].size() != 0);
        check("vc_count", vc_count, exp_cnt);
        check("in_ready", in_ready, sb[vc].size() != DEPTH);
        check("out_valid", out_valid, exp_ov);
        check("out_vc", out_vc, sel[1:0]);
`ifndef VC_PLANE_CHECK_EN
        check("sel_error", sel_error, 1'b0);
`endif
        if (exp_ov) check("out_data", out_data, sb[sel[1:0]][0]);
        if (exp_ov && ordy) void'(sb[sel[1:0]].pop_front());
        if (acc) sb[vc].push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; vc_plane_sel = 5'd0;
        rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_vc_count", vc_count, 12'h0);
        check("rst_sel_error", sel_error, 1'b0);
        for (int i = 0; i < VC; i++) sb[i].delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vc = 2'd0; in_data = 32'h0;
        vc_plane_sel = 5'd0; out_ready = 1'b0;
        do_reset();

        cycle(1'b1, 2'd2, 32'hA5, 5'd0, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 5'd2, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 5'd2, 1'b1);
        cycle(1'b0, 2'd2, 32'h0, 5'd2, 1'b0);

        for (int i = 0; i < 5; i++) cycle(1'b1, 2'd1, 32'h10 + i, 5'd0, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);
        cycle(1'b0, 2'd1, 32'h0, 5'd0, 1'b0);

        cycle(1'b1, 2'd1, 32'h15, 5'd1, 1'b1);
        cycle(1'b1, 2'd1, 32'h16, 5'd1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd1, 32'h0, 5'd1, 1'b1);

        for (int i = 0; i < VC; i++) cycle(1'b1, 2'(i), 32'h100 + 32'(i * 16), 5'd4, 1'b0);
        for (int s = 0; s <= VC; s++) cycle(1'b0, 2'd0, 32'h0, 5'(s), 1'b0);
        for (int s = 0; s < VC; s++) cycle(1'b0, 2'(s), 32'h0, 5'(s), 1'b0);

        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                  5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 32'h200 + i, 5'd0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_vc = 2'd0; in_data = 32'h2FF; out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_vc_count", vc_count, 12'h0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        for (int i = 0; i < VC; i++) sb[i].delete();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_release_in_ready", in_ready, 1'b1);
        cycle(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);

`ifdef VC_PLANE_CHECK_EN
        do_reset();
        cycle(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);
        check("chk_seq_0", sel_error, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 5'd1, 1'b0);
        check("chk_seq_1", sel_error, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 5'd3, 1'b0);
        check("chk_seq_3", sel_error, 1'b1);
        cycle(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);
        check("chk_sticky", sel_error, 1'b1);
        do_reset();
        cycle(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 5'd4, 1'b0);
        check("chk_sel4", sel_error, 1'b1);
        do_reset();
        cycle(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 5'd0, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 5'd1, 1'b0);
        check("chk_hold_ok", sel_error, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
